// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes, RV32I opcode constants and widths.
// Imported by the decode stage and the ALU.
package alu_pkg;

    localparam int XLEN      = 32;
    localparam int ALU_OP_W  = 4;
    localparam int REG_IDX_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SLT  = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // Immediate format selector for alu_imm_gen
    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_U    = 2'd3
    } imm_sel_e;

    // funct3 -> ALU op; alt picks SUB on 000 and SRA on 101
    function automatic alu_op_e f3_to_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_imm_gen.sv
// alu_imm_gen: forms I/S/U immediates from the RV32I instruction word and
// sign-extends them to DATA_WIDTH. IMM_NONE yields zero.
module alu_imm_gen
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:7]           instr_hi,
    input  imm_sel_e              sel,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [31:0] raw;

    // Select immediate format; all formats carry their sign in bit 31
    always_comb begin
        raw = '0;
        case (sel)
            IMM_I:   raw = {{20{instr_hi[31]}}, instr_hi[31:20]};
            IMM_S:   raw = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
            IMM_U:   raw = {instr_hi[31:12], 12'b0};
            default: raw = '0;
        endcase
        imm = DATA_WIDTH'($signed(raw));
    end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I ALU decode with a main output register and one
// skid register, so in_ready is registered and never depends on out_ready.
// Optional feature: define ALU_DECODE_ILLEGAL_EN to add out_illegal.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OP_CODE_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_CODE_WIDTH-1:0] out_alu_op,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic [DATA_WIDTH-1:0]    out_imm,
    output logic                     out_src2_imm,
    output logic                     out_reg_write
`ifdef ALU_DECODE_ILLEGAL_EN
    ,
    output logic                     out_illegal
`endif
);

    typedef struct packed {
        logic [OP_CODE_WIDTH-1:0] alu_op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [DATA_WIDTH-1:0]    imm;
        logic                     src2_imm;
        logic                     reg_write;
`ifdef ALU_DECODE_ILLEGAL_EN
        logic                     illegal;
`endif
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    alu_op_e    dec_op;
    imm_sel_e   imm_sel;
    logic [DATA_WIDTH-1:0] dec_imm;
    bundle_t    dec;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    alu_imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .instr_hi (in_instr[31:7]),
        .sel      (imm_sel),
        .imm      (dec_imm)
    );

`ifdef ALU_DECODE_ILLEGAL_EN
    logic [6:0] funct7;
    logic       f7_ok;
    assign funct7 = in_instr[31:25];
    assign f7_ok  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
`endif

    // Combinational decode of the incoming instruction into a bundle
    always_comb begin
        dec_op        = ALU_ADD;
        imm_sel       = IMM_NONE;
        dec           = '0;
        dec.rs1       = in_instr[19:15];
        dec.rs2       = in_instr[24:20];
        dec.rd        = in_instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec_op        = f3_to_alu_op(funct3, in_instr[30]);
                dec.reg_write = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
                dec.illegal   = !f7_ok;
`endif
            end
            OPC_OP_IMM: begin
                // ADDI has no SUB form; only the right shift uses bit 30
                dec_op        = f3_to_alu_op(funct3, (funct3 == 3'b101) && in_instr[30]);
                imm_sel       = IMM_I;
                dec.src2_imm  = 1'b1;
                dec.reg_write = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
                dec.illegal   = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                                ((funct3 == 3'b101) && !f7_ok);
`endif
            end
            OPC_LUI: begin
                dec.rs1       = '0;
                imm_sel       = IMM_U;
                dec.src2_imm  = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                imm_sel       = IMM_I;
                dec.src2_imm  = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_STORE: begin
                imm_sel       = IMM_S;
                dec.src2_imm  = 1'b1;
            end
            default: begin
`ifdef ALU_DECODE_ILLEGAL_EN
                dec.illegal   = 1'b1;
`endif
            end
        endcase
`ifdef ALU_DECODE_ILLEGAL_EN
        if (dec.illegal) dec.reg_write = 1'b0;
`endif
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
        dec.alu_op = OP_CODE_WIDTH'(dec_op);
        dec.imm    = dec_imm;
    end

    bundle_t main_q, main_d, skid_q, skid_d;
    logic    main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic    in_fire, out_fire;

    assign in_ready = !skid_vld_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_vld_q && out_ready;

    // Next-state for main/skid: main refills from skid first to keep order
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!main_vld_q || out_fire) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_fire) begin
                main_d     = dec;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    // State registers; reset drops any held bundles and zeroes payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign out_valid     = main_vld_q;
    assign out_alu_op    = main_q.alu_op;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_rd        = main_q.rd;
    assign out_imm       = main_q.imm;
    assign out_src2_imm  = main_q.src2_imm;
    assign out_reg_write = main_q.reg_write;
`ifdef ALU_DECODE_ILLEGAL_EN
    assign out_illegal   = main_q.illegal;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: table vectors, hand-written stall/reset sequences and
// randomized traffic checked against a behavioural decode model + scoreboard.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        src2;
        logic        rw;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

`ifdef ALU_DECODE_ILLEGAL_EN
    localparam bit ILL_ON = 1'b1;
`else
    localparam bit ILL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm;
    logic        out_src2_imm, out_reg_write;
    logic        ill_w;

    alu_decode_stage #(.DATA_WIDTH(32), .OP_CODE_WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_op    (out_alu_op),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_src2_imm  (out_src2_imm),
        .out_reg_write (out_reg_write)
`ifdef ALU_DECODE_ILLEGAL_EN
        ,
        .out_illegal   (ill_w)
`endif
    );
`ifndef ALU_DECODE_ILLEGAL_EN
    assign ill_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 0;
    exp_t sb[$];

    // Reference decode straight from the instruction-set rules
    function automatic exp_t model(input logic [31:0] i);
        exp_t e;
        logic [3:0] base [8];
        logic [6:0] f7;
        logic [2:0] f3;
        base = '{4'd0, 4'd5, 4'd9, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};
        f7 = i[31:25];
        f3 = i[14:12];
        e = '0;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd  = i[11:7];
        if (i[6:0] == 7'h33) begin
            e.op = base[f3];
            if (f3 == 3'd0 && f7[5]) e.op = 4'd1;
            if (f3 == 3'd5 && f7[5]) e.op = 4'd7;
            e.rw = 1;
            e.ill = !(f7 == 7'd0 || f7 == 7'd32);
        end else if (i[6:0] == 7'h13) begin
            e.op = base[f3];
            if (f3 == 3'd5 && i[30]) e.op = 4'd7;
            e.imm = 32'($signed(i[31:20]));
            e.src2 = 1; e.rw = 1;
            e.ill = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'd32);
        end else if (i[6:0] == 7'h37) begin
            e.rs1 = 0; e.imm = {i[31:12], 12'h000}; e.src2 = 1; e.rw = 1;
        end else if (i[6:0] == 7'h03) begin
            e.imm = 32'($signed(i[31:20])); e.src2 = 1; e.rw = 1;
        end else if (i[6:0] == 7'h23) begin
            e.imm = 32'($signed({i[31:25], i[11:7]})); e.src2 = 1;
        end else begin
            e.ill = 1;
        end
        if (ILL_ON && e.ill) e.rw = 0;
        if (!ILL_ON) e.ill = 0;
        if (e.rd == 0) e.rw = 0;
        return e;
    endfunction

    function automatic exp_t get_dut();
        exp_t g;
        g.op = out_alu_op; g.rs1 = out_rs1; g.rs2 = out_rs2; g.rd = out_rd;
        g.imm = out_imm; g.src2 = out_src2_imm; g.rw = out_reg_write; g.ill = ill_w;
        return g;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_b(input string nm, input exp_t got, input exp_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got op=%0h rs1=%0d rs2=%0d rd=%0d imm=%0h s2=%0b rw=%0b ill=%0b exp op=%0h rs1=%0d rs2=%0d rd=%0d imm=%0h s2=%0b rw=%0b ill=%0b",
                     nm, got.op, got.rs1, got.rs2, got.rd, got.imm, got.src2, got.rw, got.ill,
                     exp.op, exp.rs1, exp.rs2, exp.rd, exp.imm, exp.src2, exp.rw, exp.ill);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: inputs and outputs are stable around the falling edge
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_unexpected_out", 1, 0);
                else chk_b("sb_order", get_dut(), sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(model(in_instr));
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 6);
        case (k)
            0, 1: begin r[6:0] = 7'h33; if ($urandom_range(0, 7) != 0) r[31:25] = {1'b0, r[30], 5'b0}; end
            2:    begin r[6:0] = 7'h13; if ($urandom_range(0, 3) != 0) r[31:25] = {1'b0, r[30], 5'b0}; end
            3:    r[6:0] = 7'h37;
            4:    r[6:0] = 7'h03;
            5:    r[6:0] = 7'h23;
            default: ;
        endcase
        return r;
    endfunction

    vec_t vt [9];

    initial begin
        // {instr, {op, rs1, rs2, rd, imm, src2, rw, ill}}
        vt[0] = '{32'h40B50533, '{4'h1, 5'd10, 5'd11, 5'd10, 32'h0,        1'b0, 1'b1, 1'b0}};
        vt[1] = '{32'hFFF00093, '{4'h0, 5'd0,  5'd31, 5'd1,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b0}};
        vt[2] = '{32'h40335293, '{4'h7, 5'd6,  5'd3,  5'd5,  32'h00000403, 1'b1, 1'b1, 1'b0}};
        vt[3] = '{32'h123451B7, '{4'h0, 5'd0,  5'd3,  5'd3,  32'h12345000, 1'b1, 1'b1, 1'b0}};
        vt[4] = '{32'hFFFFFFFF, '{4'h0, 5'd31, 5'd31, 5'd31, 32'h0,        1'b0, 1'b0, ILL_ON}};
        vt[5] = '{32'hFFC12283, '{4'h0, 5'd2,  5'd28, 5'd5,  32'hFFFFFFFC, 1'b1, 1'b1, 1'b0}};
        vt[6] = '{32'h0063A423, '{4'h0, 5'd7,  5'd6,  5'd8,  32'h00000008, 1'b1, 1'b0, 1'b0}};
        vt[7] = '{32'h00208033, '{4'h0, 5'd1,  5'd2,  5'd0,  32'h0,        1'b0, 1'b0, 1'b0}};
        vt[8] = '{32'h005231B3, '{4'h8, 5'd4,  5'd5,  5'd3,  32'h0,        1'b0, 1'b1, 1'b0}};

        rst = 1; in_valid = 0; out_ready = 0; in_instr = '0;
        step(); step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_payload", {out_imm, out_alu_op, out_rd, out_rs1, out_rs2, out_reg_write, out_src2_imm, ill_w}, 0);
        step();
        rst = 0;
        mon_en = 1;

        // Table vectors: one-cycle latency, no stall
        foreach (vt[n]) begin
            step();
            in_valid = 1; in_instr = vt[n].instr; out_ready = 1;
            step();
            in_valid = 0;
            @(negedge clk);
            chk("vec_latency", out_valid, 1);
            chk_b($sformatf("vec%0d", n), get_dut(), vt[n].e);
        end
        step(); step();

        // Stall: three offered while output blocked
        out_ready = 0; in_valid = 1; in_instr = vt[0].instr;
        step();
        in_instr = vt[1].instr;
        @(negedge clk);
        chk("stall_first_valid", out_valid, 1);
        chk("stall_first_ready", in_ready, 1);
        step();
        in_instr = vt[3].instr;
        @(negedge clk);
        chk("stall_skid_full", in_ready, 0);
        chk_b("stall_hold1", get_dut(), vt[0].e);
        step();
        @(negedge clk);
        chk("stall_third_held", in_ready, 0);
        chk_b("stall_hold2", get_dut(), vt[0].e);
        step();
        @(negedge clk);
        chk_b("stall_hold3", get_dut(), vt[0].e);
        step();
        out_ready = 1;
        step();
        @(negedge clk);
        chk_b("release_b", get_dut(), vt[1].e);
        chk("release_ready", in_ready, 1);
        step();
        in_valid = 0;
        @(negedge clk);
        chk_b("release_c", get_dut(), vt[3].e);
        step();
        @(negedge clk);
        chk("release_empty", out_valid, 0);

        // Reset during stall with skid occupied
        out_ready = 0; in_valid = 1; in_instr = vt[2].instr;
        step();
        in_instr = vt[5].instr;
        step();
        in_valid = 0;
        #2;
        chk("pre_rst_skid", in_ready, 0);
        rst = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_payload", {out_imm, out_rd, out_alu_op}, 0);
        sb.delete();
        step();
        rst = 0;
        out_ready = 1;
        step(); step();
        @(negedge clk);
        chk("skid_lost", out_valid, 0);

        // Random traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            step();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 2) != 0);
        end
        step();
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        step();
        @(negedge clk);
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_out_idle", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction and immediate width.
REQ-002 SHALL have parameter OP_CODE_WIDTH, default 4: width of the ALU operation code produced.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: upstream instruction valid.
REQ-006 SHALL have port in_ready, output, 1: stage can accept an instruction.
REQ-007 SHALL have port in_instr, input, DATA_WIDTH: RV32I instruction word.
REQ-008 SHALL have port out_valid, output, 1: decoded bundle valid.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts bundle.
REQ-010 SHALL have port out_alu_op, output, OP_CODE_WIDTH: ALU op code.
REQ-011 SHALL have ports out_rs1, out_rs2, out_rd, output, 5 each: register indices.
REQ-012 SHALL have port out_imm, output, DATA_WIDTH: sign-extended immediate.
REQ-013 SHALL have ports out_src2_imm and out_reg_write, output, 1 each: ALU in2 selects out_imm; rd written.

Function
REQ-014 SHALL emit ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLTU 1000, SLT 1001.
REQ-015 SHALL decode OP (0110011) by funct3: 000 ADD/SUB by funct7[5], 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7[5], 110 OR, 111 AND; src2_imm 0, reg_write 1.
REQ-016 SHALL decode OP-IMM (0010011) identically except 000 always ADD, 101 selects SRA by instr[30]; I-immediate, src2_imm 1, reg_write 1.
REQ-017 SHALL decode LUI (0110111) as ADD, rs1 forced 0, U-immediate, src2_imm 1, reg_write 1.
REQ-018 SHALL decode LOAD (0000011) as ADD with I-immediate, reg_write 1; STORE (0100011) as ADD with S-immediate, reg_write 0; both src2_imm 1.
REQ-019 SHALL decode any other opcode as ADD, reg_write 0, src2_imm 0, imm 0.
REQ-020 SHALL force reg_write 0 whenever rd is 0.
REQ-021 SHALL transfer input on in_valid&&in_ready and output on out_valid&&out_ready.
REQ-022 SHALL present a bundle on out_valid exactly one cycle after acceptance when not stalled.
REQ-023 SHALL hold a main output register plus one skid register; in_ready SHALL equal !skid_valid (registered, no combinational path from out_ready).
REQ-024 SHALL, when main is valid and stalled and an input is accepted, store it in skid; on downstream accept, skid moves to main the same edge.
REQ-025 SHALL keep all out_* payload stable while out_valid&&!out_ready.
REQ-026 SHALL, on simultaneous output transfer and input accept with skid empty, load the new bundle directly into main.
REQ-027 SHALL preserve order; no bundle dropped or duplicated.

Reset
REQ-028 SHALL, on rst assertion, immediately clear out_valid and skid_valid, and zero all payload registers; in_ready reads 1.
REQ-029 SHALL discard any in-flight or skidded bundle when rst asserts mid-stall.

Configuration
REQ-030 SHALL, with ALU_DECODE_ILLEGAL_EN defined, add output out_illegal (1 bit), set for REQ-019 opcodes and for OP with funct7 not 0000000/0100000 or OP-IMM shifts with bad funct7 (these then also reg_write 0); reset 0.
REQ-031 SHALL, without ALU_DECODE_ILLEGAL_EN, omit out_illegal and decode such funct7 values by bit 5 only.

Structure
REQ-032 SHALL place ALU op enum, RV32I opcode constants and widths in shared package alu_pkg, also used by ALU.
REQ-033 SHALL implement immediate formation (I/S/U) in sub-module alu_imm_gen.

Verification
REQ-034 SHALL test 0x40B50533 -> next cycle alu_op 0001, rs1 10, rs2 11, rd 10, src2_imm 0, reg_write 1.
REQ-035 SHALL test 0xFFF00093 -> alu_op 0000, imm 0xFFFFFFFF, rd 1, src2_imm 1; 0x40335293 -> alu_op 0111, imm[4:0] 3.
REQ-036 SHALL test 0x123451B7 -> alu_op 0000, rs1 0, imm 0x12345000, rd 3.
REQ-037 SHALL test out_ready 0 for 3 cycles with 3 inputs offered -> two accepted, in_ready 0, third held; release -> all three in order.
REQ-038 SHALL test 0xFFFFFFFF -> reg_write 0, out_illegal 1 (macro on); port absent (macro off).
REQ-039 SHALL test rst asserted during stall -> out_valid 0 without clock edge, in_ready 1, skid content lost.
